// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: drives a req/gnt/rvalid data bus,
// formats sub-word loads/stores, stalls the pipeline and flags misalignment/timeouts.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_rd,
    input  logic        mem_ram_we,
    input  logic [2:0]  mem_rw_op,
    input  logic [31:0] mem_ALU_C,
    input  logic [31:0] mem_rD2,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          to_hit;
    logic [31:0]   addr_q, wdata_q;
    logic [2:0]    op_q;
    logic          we_q;
    logic          pending, mis, cap;
    logic          ld_valid_nxt, misalign_nxt, bus_err_nxt, ld_upd, ld_clr;
    logic [3:0]    be_fmt;
    logic [31:0]   wd_fmt, ld_fmt, ld_shift;

    // funct3[1:0]: 00 byte, 01 half, 1x word (covers the unused codes too)
    function automatic logic is_byte(input logic [2:0] op);
        return op[1:0] == 2'b00;
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return op[1:0] == 2'b01;
    endfunction

    assign pending = mem_valid & (mem_rd | mem_ram_we);
    assign stall   = pending & (state != DONE);
    assign mis     = is_byte(mem_rw_op) ? 1'b0 :
                     is_half(mem_rw_op) ? mem_ALU_C[0] : |mem_ALU_C[1:0];

    assign cnt_inc = cnt + CW'(1);
    assign to_hit  = (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        be_fmt = 4'b1111;
        wd_fmt = wdata_q;
        if (is_byte(op_q)) begin
            be_fmt = 4'b0001 << addr_q[1:0];
            wd_fmt = {4{wdata_q[7:0]}};
        end else if (is_half(op_q)) begin
            be_fmt = addr_q[1] ? 4'b1100 : 4'b0011;
            wd_fmt = {2{wdata_q[15:0]}};
        end
    end

    always_comb begin
        ld_shift = dbus_rdata >> {addr_q[1:0], 3'b000};
        ld_fmt   = ld_shift;
        if (is_byte(op_q))
            ld_fmt = op_q[2] ? {24'b0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
        else if (is_half(op_q))
            ld_fmt = op_q[2] ? {16'b0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
    end

    // Bus is only driven while requesting, so reset or any other state forces it to 0
    assign dbus_req   = (state == REQ);
    assign dbus_we    = dbus_req & we_q;
    assign dbus_addr  = dbus_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign dbus_be    = dbus_req ? be_fmt : 4'b0;
    assign dbus_wdata = dbus_req ? wd_fmt : 32'b0;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap          = 1'b0;
        ld_valid_nxt = 1'b0;
        misalign_nxt = 1'b0;
        bus_err_nxt  = 1'b0;
        ld_upd       = 1'b0;
        ld_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    cap = 1'b1;
                    if (mis) begin
                        state_nxt    = DONE;
                        misalign_nxt = 1'b1;
                    end else begin
                        state_nxt = REQ;
                        cnt_nxt   = '0;
                    end
                end
            end
            REQ: begin
                if (dbus_gnt) begin
                    state_nxt = we_q ? DONE : WAIT_RSP;
                    cnt_nxt   = '0;
                end else if (to_hit) begin
                    state_nxt   = DONE;
                    bus_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            WAIT_RSP: begin
                if (dbus_rvalid) begin
                    state_nxt    = DONE;
                    ld_upd       = 1'b1;
                    ld_valid_nxt = 1'b1;
                end else if (to_hit) begin
                    state_nxt   = DONE;
                    bus_err_nxt = 1'b1;
                    ld_clr      = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_q     <= '0;
            we_q     <= 1'b0;
            ld_data  <= '0;
            ld_valid <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ld_valid <= ld_valid_nxt;
            misalign <= misalign_nxt;
            bus_err  <= bus_err_nxt;
            if (cap) begin
                addr_q  <= mem_ALU_C;
                wdata_q <= mem_rD2;
                op_q    <= mem_rw_op;
                we_q    <= mem_ram_we;
            end
            if (ld_upd)
                ld_data <= ld_fmt;
            else if (ld_clr)
                ld_data <= '0;
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller. It sits downstream of the EX/MEM pipeline register and consumes its address, store data, read/write op and write-enable.
- Drives a request/grant/response data bus and formats sub-word load and store data.
- Stalls the pipeline until each access completes.
- Flags misaligned accesses and bus timeouts instead of issuing or waiting forever.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waited in REQ or WAIT_RSP before bus_err; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  instruction in MEM stage is valid
- mem_rd  in  1  instruction is a load
- mem_ram_we  in  1  instruction is a store; has priority if mem_rd is also set
- mem_rw_op  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W
- mem_ALU_C  in  32  byte address
- mem_rD2  in  32  store data
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word address, {addr[31:2],2'b00}
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated write data
- dbus_gnt  in  1  request accepted this cycle
- dbus_rvalid  in  1  read data valid
- dbus_rdata  in  32  read word
- stall  out  1  hold the IF..MEM stages
- ld_data  out  32  formatted load result
- ld_valid  out  1  ld_data valid, one-cycle pulse
- misalign  out  1  misaligned access, one-cycle pulse
- bus_err  out  1  timeout, one-cycle pulse

Behaviour:
- States: IDLE, REQ, WAIT_RSP, DONE.
- Reset (synchronous): state=IDLE, timeout counter=0, captured address/op/data=0, ld_data=0. ld_valid, misalign and bus_err are 0. The bus outputs are 0 from the first cycle after rst is sampled, including when rst arrives mid-access; any in-flight response is ignored.
- Access pending = mem_valid & (mem_rd | mem_ram_we).
- stall = pending & (state != DONE). It is combinational, so it is 1 in IDLE during the same cycle a new access appears.
- IDLE:
  - If pending, capture addr, op, wdata and we.
  - If misaligned, go to DONE with misalign=1. Misaligned means H/HU/SH with addr[0]=1, or W with addr[1:0]!=0.
  - Otherwise go to REQ and clear the counter.
- REQ:
  - dbus_req=1; dbus_we, dbus_addr, dbus_be and dbus_wdata come from the captured registers and stay stable until gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT_RSP with the counter cleared.
  - If the counter reaches TIMEOUT_CYCLES without gnt, go to DONE with bus_err=1.
- WAIT_RSP:
  - dbus_req=0. dbus_rvalid is sampled only in this state; the earliest response is the cycle after gnt.
  - On rvalid, register the formatted ld_data and go to DONE with ld_valid=1.
  - On timeout, go to DONE with bus_err=1 and ld_data=0.
- DONE: lasts exactly one cycle with stall=0, so the pipeline advances at this edge. Then return to IDLE, clear the pulses and hold ld_data.
- Store formatting, with o = addr[1:0]:
  - SB: be=4'b0001<<o, wdata={4{rD2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{rD2[15:0]}}.
  - SW: be=4'b1111, wdata=rD2.
- Load formatting: s = rdata >> (8*o). B and H are sign-extended from bit 7 or 15; BU and HU are zero-extended; W passes through.
- Minimum latency:
  - Store: 3 cycles (IDLE, REQ with gnt, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT_RSP with rvalid, DONE).
- A misaligned access issues no bus request and leaves ld_data unchanged.
- Back-to-back accesses: the next access is seen in IDLE on the cycle after DONE; no instruction is issued twice.

Test Plan:
- SW addr=0x100, rD2=0xDEADBEEF, gnt on the first REQ cycle -> dbus_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1. stall is high for 2 cycles, then DONE.
- LB addr=0x203, rdata=0x80FF1234 with rvalid the cycle after gnt -> ld_data=0xFFFFFF80 and ld_valid pulses in DONE. The same access as LBU -> 0x00000080.
- SH addr=0x22, rD2=0x0000ABCD -> be=1100, wdata=0xABCDABCD. LHU addr=0x22 with rdata=0xABCD0000 -> ld_data=0x0000ABCD.
- LW addr=0x102 -> misalign pulses, dbus_req never asserts, stall is high only during the IDLE cycle.
- gnt withheld with TIMEOUT_CYCLES=4 -> bus_err pulses after 4 REQ cycles, then IDLE. Separately, rvalid withheld after gnt -> bus_err and ld_data=0.
- rst asserted while in WAIT_RSP, then rvalid the following cycle -> IDLE, all outputs 0, the late response is ignored, no ld_valid.
